// File: rtl/sigmoid_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_pkg
// Shared constants and helpers for the sigmoid activation front-end.
//   IN_W / OUT_W / K_MAX : datapath widths and last table index (x = 6.0)
//   SAT_MAG              : |x| at or above which the index saturates (6.0 in Q8.8)
//   HALF                 : 0.5 in the Q.8 fraction domain (rounding constant)
//   ADDR_TAB             : table index k -> ROM address, round(k * 25.6)
//   k_of_mag             : |x| (Q8.8) -> nearest 0.1-step table index
//   addr_is_key          : true when an address is one of the 61 ROM keys
// -----------------------------------------------------------------------------
package sigmoid_pkg;

   localparam int IN_W  = 16;
   localparam int OUT_W = 8;
   localparam int K_MAX = 60;
   localparam int K_W   = 6;

   localparam logic [15:0] SAT_MAG = 16'h0600;
   localparam logic [7:0]  HALF    = 8'd128;

   // ROM key for each grid point: the Q8.8 encoding of k * 0.1, rounded.
   localparam logic [15:0] ADDR_TAB [0:K_MAX] = '{
      16'd0,    16'd26,   16'd51,   16'd77,   16'd102,
      16'd128,  16'd154,  16'd179,  16'd205,  16'd230,
      16'd256,  16'd282,  16'd307,  16'd333,  16'd358,
      16'd384,  16'd410,  16'd435,  16'd461,  16'd486,
      16'd512,  16'd538,  16'd563,  16'd589,  16'd614,
      16'd640,  16'd666,  16'd691,  16'd717,  16'd742,
      16'd768,  16'd794,  16'd819,  16'd845,  16'd870,
      16'd896,  16'd922,  16'd947,  16'd973,  16'd998,
      16'd1024, 16'd1050, 16'd1075, 16'd1101, 16'd1126,
      16'd1152, 16'd1178, 16'd1203, 16'd1229, 16'd1254,
      16'd1280, 16'd1306, 16'd1331, 16'd1357, 16'd1382,
      16'd1408, 16'd1434, 16'd1459, 16'd1485, 16'd1510,
      16'd1536
   };

   // Round-half-up of |x| / 0.1. Below saturation |x| fits in 11 bits, so
   // mag*10 + 0.5 stays under 2^14 and a 16-bit product is ample.
   function automatic logic [K_W-1:0] k_of_mag(input logic [16:0] mag);
      logic [15:0] scaled;
      scaled = 16'(mag[10:0]) * 16'd10 + {8'd0, HALF};
      if (mag >= {1'b0, SAT_MAG})
         return K_W'(K_MAX);
      return K_W'(scaled >> 8);
   endfunction

   function automatic logic addr_is_key(input logic [15:0] a);
      for (int k = 0; k <= K_MAX; k++)
         if (ADDR_TAB[k] == a)
            return 1'b1;
      return 1'b0;
   endfunction

endpackage

// File: rtl/sigmoid_act_rom.sv
// -----------------------------------------------------------------------------
// rom
// Sigmoid lookup table for x >= 0 on the 0.1-step grid, x = 0.0 .. 6.0.
// data[7:0] = round(256 * sigmoid(k * 0.1)), upper byte zero. Combinational.
//   addr : Q8.8 key, one of the 61 grid addresses (input)
//   data : table word; undefined meaning for any non-key address (output)
// -----------------------------------------------------------------------------
module rom (
   input  logic [15:0] addr,
   output logic [15:0] data
);

   always_comb begin
      // NOTE: default assignment first so every path drives data and no latch is inferred.
      data = 16'h0000;
      case (addr)
         16'd0:    data = 16'd128;
         16'd26:   data = 16'd134;
         16'd51:   data = 16'd141;
         16'd77:   data = 16'd147;
         16'd102:  data = 16'd153;
         16'd128:  data = 16'd159;
         16'd154:  data = 16'd165;
         16'd179:  data = 16'd171;
         16'd205:  data = 16'd177;
         16'd230:  data = 16'd182;
         16'd256:  data = 16'd187;
         16'd282:  data = 16'd192;
         16'd307:  data = 16'd197;
         16'd333:  data = 16'd201;
         16'd358:  data = 16'd205;
         16'd384:  data = 16'd209;
         16'd410:  data = 16'd213;
         16'd435:  data = 16'd216;
         16'd461:  data = 16'd220;
         16'd486:  data = 16'd223;
         16'd512:  data = 16'd225;
         16'd538:  data = 16'd228;
         16'd563:  data = 16'd230;
         16'd589:  data = 16'd233;
         16'd614:  data = 16'd235;
         16'd640:  data = 16'd237;
         16'd666:  data = 16'd238;
         16'd691:  data = 16'd240;
         16'd717:  data = 16'd241;
         16'd742:  data = 16'd243;
         16'd768:  data = 16'd244;
         16'd794:  data = 16'd245;
         16'd819:  data = 16'd246;
         16'd845:  data = 16'd247;
         16'd870:  data = 16'd248;
         16'd896:  data = 16'd248;
         16'd922:  data = 16'd249;
         16'd947:  data = 16'd250;
         16'd973:  data = 16'd250;
         16'd998:  data = 16'd251;
         16'd1024: data = 16'd251;
         16'd1050: data = 16'd252;
         16'd1075: data = 16'd252;
         16'd1101: data = 16'd253;
         16'd1126: data = 16'd253;
         16'd1152: data = 16'd253;
         16'd1178: data = 16'd253;
         16'd1203: data = 16'd254;
         16'd1229: data = 16'd254;
         16'd1254: data = 16'd254;
         16'd1280: data = 16'd254;
         16'd1306: data = 16'd254;
         16'd1331: data = 16'd255;
         16'd1357: data = 16'd255;
         16'd1382: data = 16'd255;
         16'd1408: data = 16'd255;
         16'd1434: data = 16'd255;
         16'd1459: data = 16'd255;
         16'd1485: data = 16'd255;
         16'd1510: data = 16'd255;
         16'd1536: data = 16'd255;
         default:  data = 16'h0000;
      endcase
   end

endmodule

// File: rtl/sigmoid_act.sv
// -----------------------------------------------------------------------------
// sigmoid_act
// Three-stage activation pipeline: signed Q8.8 pre-activation in, Q0.8
// sigmoid out. S1 quantizes |x| to the 0.1 grid, S2 registers the ROM key,
// S3 applies odd symmetry (sigmoid(-x) = 1 - sigmoid(x)) to the ROM word.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : upstream handshake (accumulator side)
//   in_data             : signed Q8.8 pre-activation
//   out_valid/out_ready : downstream handshake (layer output buffer side)
//   out_data            : activation, unsigned Q0.8 (128 = 0.5)
// -----------------------------------------------------------------------------
module sigmoid_act
   import sigmoid_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
);

   logic            adv;
   logic [16:0]     mag;

   logic            v1;
   logic            sign1;
   logic [K_W-1:0]  k1;

   logic            v2;
   logic            sign2;
   logic [15:0]     addr2;

   logic [15:0]     rom_data;
   logic [7:0]      d;
   logic [8:0]      neg;
   logic [7:0]      unused_rom_hi;

   // One global enable: the whole pipe moves or the whole pipe holds, so
   // bubbles are kept while stalled.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   // 17-bit magnitude so that 0x8000 maps to 32768 rather than wrapping.
   assign mag = in_data[IN_W-1] ? (17'h10000 - {1'b0, in_data}) : {1'b0, in_data};

   // ROM address comes straight from a register: no input-to-ROM comb path.
   rom u_rom (
      .addr (addr2),
      .data (rom_data)
   );

   assign d             = rom_data[7:0];
   assign unused_rom_hi = rom_data[15:8];
   // Valid ROM data is 128..255, so 256 - d lands in 1..128.
   assign neg           = 9'd256 - {1'b0, d};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         sign1     <= 1'b0;
         k1        <= '0;
         v2        <= 1'b0;
         sign2     <= 1'b0;
         addr2     <= ADDR_TAB[0];
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (adv) begin
         // NOTE: non-blocking assignments so each stage reads the previous stage's old value.
         v1        <= in_valid & in_ready;
         sign1     <= in_data[IN_W-1];
         k1        <= k_of_mag(mag);
         v2        <= v1;
         sign2     <= sign1;
         addr2     <= ADDR_TAB[k1];
         out_valid <= v2;
         out_data  <= sign2 ? neg[OUT_W-1:0] : d;
      end
   end

   // Every issued address must be a table key; anything else reads garbage.
   a_addr_is_key : assert property (@(posedge clk) disable iff (!rst_n) addr_is_key(addr2))
      else $error("rom address %0d is not a table key", addr2);

endmodule

// File: tb/tb_sigmoid_act.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_act
// Directed and randomized stimulus for sigmoid_act against a real-arithmetic
// sigmoid reference and an in-order expectation queue.
// -----------------------------------------------------------------------------
module tb_sigmoid_act;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int exp_q [$];
   int acc_q [$];
   bit lat_chk;

   logic [15:0] dir_in  [11] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0033, 16'h000C, 16'h000D,
                                 16'h0600, 16'h0700, 16'h7FFF, 16'hF900, 16'h8000};
   int          dir_exp [11] = '{128, 187, 69, 141, 128, 134, 255, 255, 255, 1, 1};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sigmoid_act dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Reference: nearest 0.1 grid point of |x| (saturating at 6.0), then
   // 256 / (1 + e^-x) rounded, mirrored for negative inputs.
   function automatic int model(logic [15:0] x);
      int  mag;
      int  k;
      int  dv;
      real p;
      mag = x[15] ? 65536 - int'(x) : int'(x);
      k   = (mag >= 1536) ? 60 : (mag * 10 + 128) / 256;
      p   = 256.0 / (1.0 + $exp(-k / 10.0));
      dv  = $rtoi(p + 0.5);
      return x[15] ? 256 - dv : dv;
   endfunction

   task automatic check(input string tag, input int obs, input int want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   // One clock of traffic, entered and left at a falling edge.
   // want < 0 means the expected output comes from the reference model.
   task automatic cycle(input bit v, input logic [15:0] dat, input bit rdy, input int want);
      int e;
      int a;
      in_valid  = v;
      in_data   = dat;
      out_ready = rdy;
      #1;
      check("spurious_out", int'(out_valid && out_ready && exp_q.size() == 0), 0);
      if (out_valid && out_ready && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = acc_q.pop_front();
         check("out_data", int'(out_data), e);
         if (lat_chk) check("latency", cyc - a, 3);
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(want < 0 ? model(dat) : want);
         acc_q.push_back(cyc);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++)
         cycle(1'b0, 16'h0000, 1'b1, -1);
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      logic [15:0] s [5];

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b1;
      lat_chk   = 1'b1;
      #2;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_data",  int'(out_data), 0);
      check("reset_in_ready",  int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single samples, one at a time, with fixed expected activations.
      for (int i = 0; i < 11; i++) begin
         cycle(1'b1, dir_in[i], 1'b1, dir_exp[i]);
         drain();
      end

      // Back-to-back sweep over all 61 grid points.
      for (int k = 0; k <= 60; k++) begin
         check("in_ready_stream", int'(in_ready), 1);
         cycle(1'b1, 16'((k * 128 + 2) / 5), 1'b1, -1);
      end
      drain();

      // Backpressure: three accepted, then four stalled cycles with out_valid up.
      lat_chk = 1'b0;
      for (int i = 0; i < 5; i++) s[i] = 16'($urandom);
      for (int i = 0; i < 3; i++) cycle(1'b1, s[i], 1'b1, -1);
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'b1;
         in_data   = s[3];
         out_ready = 1'b0;
         #1;
         check("stall_in_ready",  int'(in_ready), 0);
         check("stall_out_valid", int'(out_valid), 1);
         check("stall_out_data",  int'(out_data), exp_q[0]);
         @(posedge clk);
         @(negedge clk);
      end
      cycle(1'b1, s[3], 1'b1, -1);
      cycle(1'b1, s[4], 1'b1, -1);
      drain();

      // Random traffic with random gaps and random backpressure.
      for (int i = 0; i < 60; i++)
         cycle(($urandom % 4) != 0, 16'($urandom), ($urandom % 4) != 0, -1);
      drain();

      // Asynchronous reset with three samples in flight.
      lat_chk = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b1, -1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", int'(out_valid), 0);
      check("midreset_out_data",  int'(out_data), 0);
      check("midreset_in_ready",  int'(in_ready), 1);
      exp_q.delete();
      acc_q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 16'h0100, 1'b1, 187);
      drain();
      for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sigmoid_act.md
Name: sigmoid_act

Overview:
- Activation front-end for the neuron datapath. Accepts a signed Q8.8 pre-activation value from the accumulator and quantizes |x| to the 0.1-step sigmoid table grid.
- Drives the sigmoid ROM (internal instance of `rom`, 16-bit addr in, 16-bit data out, valid for x ≥ 0 only). Applies odd symmetry for negative inputs and returns an 8-bit Q0.8 activation.
- Three-stage valid/ready pipeline between the MAC accumulator and the layer output buffer.

Parameters:
- IN_W, 16, pre-activation width (signed Q8.8).
- OUT_W, 8, activation width (unsigned Q0.8; 128 = 0.5).
- K_MAX, 60, last table index (x = 6.0); inputs with |x| ≥ 6.0 saturate to this index.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  stage 1 can accept this cycle
- in_data  in  IN_W  signed Q8.8 pre-activation
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  OUT_W  sigmoid(in_data), Q0.8

Behaviour:
- Reset (asynchronous, rst_n low): all stage valid bits clear, out_valid = 0, out_data = 0, in_ready = 1. Reset mid-operation discards all in-flight samples; there is no partial output.
- Global stall: adv = out_ready | ~out_valid.
  - in_ready = adv.
  - All stage registers load only when adv = 1.
  - A transfer occurs when in_valid & in_ready.
  - Bubbles do not collapse while stalled, since adv is global.
- S1 (capture):
  - sign1 = in_data[15].
  - mag = |in_data|, computed in 17 bits so that 0x8000 gives 32768.
  - If mag ≥ 0x600: k1 = K_MAX.
  - Else: k1 = (mag*10 + 128) >> 8, i.e. round-half-up of |x|/0.1. Multiply width is ≥ 15 bits.
  - v1 = in_valid & in_ready.
- S2 (address):
  - addr2 = floor((k1*128 + 2) / 5), which equals round(k1 × 25.6).
  - Implement as a 61-entry constant table indexed by k, or a multiply-shift that matches the table for all k in 0..60.
  - Pass sign2 and v2 forward.
  - addr2 drives rom.addr directly from a register, so no combinational input path reaches the ROM.
- S3 (output):
  - d = rom.data[7:0].
  - out_data = sign2 ? (256 − d) : d, computed in 9 bits, then truncated to OUT_W.
  - Valid ROM data is in 128..255, so the negative result is in 1..128 and never overflows.
  - out_valid = v2.
- Latency: 3 cycles from accepted input to out_valid with out_ready held high. Throughput is 1 sample per clock.
- Stall with out_valid = 1 and out_ready = 0: out_data, out_valid and all stage contents are held stable; in_ready = 0.
- Boundary cases:
  - x = 0 → k = 0 → out = 128.
  - x = −0 cannot occur in two's complement.
  - 0x8000 → saturated negative → out = 1.
  - 0x7FFF → out = 255.
- Invariant: every address issued is one of the 61 ROM table keys. Any other address leaves rom.data undefined; this is a checked assertion.

Decomposition:
- Package sigmoid_pkg:
  - IN_W, OUT_W, K_MAX
  - SAT_MAG = 16'h0600
  - HALF = 8'd128
  - 61-entry k→addr constant array
  - function k_of_mag
- Sub-module: `rom` (existing sigmoid table), instantiated once in S2/S3. No other sub-modules.

Test Plan:
- Single samples, out_ready = 1:
  - 0x0000 → 128.
  - 0x0100 (1.0) → 187.
  - 0xFF00 (−1.0) → 69.
  - 0x0033 (0.2, k = 2, addr 51) → 141.
  - Each out_valid appears exactly 3 cycles after the accept.
- Rounding edge: 0x000C → 128 (k = 0); 0x000D → 134 (k = 1, addr 26).
- Saturation:
  - 0x0600 → 255, 0x0700 → 255, 0x7FFF → 255.
  - 0xF900 (−7.0) → 1, 0x8000 → 1.
  - No ROM address assertion fires.
- Back-to-back stream of 61 grid points k*0x1A-rounded (0..0x600) with out_ready = 1: outputs equal the table in order, one per cycle, in_ready never drops.
- Backpressure: stream 5 samples, hold out_ready = 0 for 4 cycles mid-stream.
  - in_ready = 0 and out_data stable while stalled.
  - No loss or duplication; order is preserved once out_ready returns.
- Reset mid-stream: assert rst_n = 0 asynchronously with 3 samples in flight.
  - out_valid = 0 and out_data = 0 immediately.
  - After release, the first new input (0x0100) yields 187 after 3 cycles and no stale data appears.
